uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter: accepts data words over a valid/ready handshake into an internal FIFO and serializes them onto the TX line as 8N1-style frames. Frames are start bit, data LSB first, optional parity bit, and one stop bit. The block sits beside the existing UART receive path under `top` and drives `uart_rxd_out` toward the host. It exists so that logic can queue bursts of bytes without waiting on the slow bit rate.

## Interface
- `BW`, 8: data bits per frame.
- `CLKS_PER_BIT`, 10416: clock cycles per bit (100 MHz / 9600 baud); must be ≥ 2.
- `DEPTH`, 16: FIFO entries; must be a power of 2, ≥ 2.
- `clk`  in  1  single system clock, rising edge.
- `i_reset`  in  1  reset; asynchronous and active-high.
- `i_data`  in  BW  word to transmit.
- `i_valid`  in  1  `i_data` valid; a write is accepted on any edge where `i_valid && o_ready`.
- `o_ready`  out  1  FIFO not full.
- `o_tx`  out  1  serial line, idle high, registered.
- `o_busy`  out  1  serializer state ≠ IDLE.
- `o_count`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation
- Reset values: `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_count`=0, FIFO empty, state IDLE, baud counter 0.
- FIFO:
  - Write on an accepted handshake.
  - Pop only in IDLE (count > 0) or on the final cycle of STOP (count > 0).
  - No bypass path: a word written to an empty FIFO is popped on the next edge.
  - Write and pop on the same edge leave `o_count` unchanged.
  - `o_ready` = (`o_count` ≠ DEPTH). Writes while full are ignored and do not corrupt data.
  - Pointers wrap modulo DEPTH.
- State machine (IDLE → START → DATA → [PARITY] → STOP):
  - IDLE: `o_tx`=1. If count > 0, pop the head into the shift register, clear the bit index and baud counter, and go to START.
  - START: `o_tx`=0 for CLKS_PER_BIT cycles.
  - DATA: `o_tx`=shift[0]. Shift right every CLKS_PER_BIT cycles; after BW bits go to PARITY (if built) or STOP.
  - PARITY: `o_tx`=XOR of the BW data bits (even parity) for CLKS_PER_BIT cycles.
  - STOP: `o_tx`=1 for CLKS_PER_BIT cycles. On the last cycle, if count > 0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Terminal count advances the bit or state and resets the counter to 0.
- Reset asserted mid-frame: `o_tx` goes high asynchronously, the FIFO is flushed, and the partial frame is abandoned.

## Timing
- `o_tx`, `o_busy`, `o_ready`, and `o_count` are all registered; no combinational input→output paths.
- Write into an empty FIFO while IDLE, accepted at edge N:
  - `o_count`=1 after edge N.
  - Pop at edge N+1; `o_tx` falls and `o_busy` rises after edge N+1.
- Each bit is exactly CLKS_PER_BIT cycles.
- Frame length is (BW+2)·CLKS_PER_BIT cycles, or (BW+3)·CLKS_PER_BIT with parity.
- Back-to-back frames are contiguous: the next start bit immediately follows the last stop-bit cycle.
- `o_ready` rises the cycle after the pop that leaves the FIFO non-full.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state is built; even parity bit is inserted between data and stop.
- `UART_TX_PARITY_EN` undefined: no PARITY state or logic; DATA goes straight to STOP.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Default constants `UART_CLKS_PER_BIT`=10416 and `UART_BW`=8, shared with the receive path.
- Sub-module `uart_sync_fifo` (params `BW`, `DEPTH`): wr/rd strobes, data out, count, full, empty. `uart_tx_fifo` instantiates it once and holds the FSM, baud counter, and shift register.

## Test plan
1. Reset: hold `i_reset` high for 3 cycles → `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_count`=0.
2. With CLKS_PER_BIT=4 and parity off, write 0xA5 → `o_tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Total 40 cycles, then IDLE with `o_busy`=0.
3. With DEPTH=16, hold `i_valid` for 20 cycles from IDLE:
   - Exactly 17 writes are accepted (one popped at the second edge).
   - `o_ready`=0 with `o_count`=16.
   - `o_ready` returns to 1 after the first stop bit completes.
   - All 17 frames go out contiguously, in order.
4. Assert `i_reset` during data bit 3 of a frame with 5 words queued → `o_tx`=1 immediately and `o_count`=0. A subsequent write of 0x3C transmits one clean frame.
5. With `UART_TX_PARITY_EN` defined, write 0x07 → parity bit 1, frame 44 cycles. Write 0x03 → parity bit 0.
6. With `o_count`=15 during STOP's final cycle, apply a simultaneous write → `o_count` stays 15 and the next START begins with no gap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and default line constants used by
// both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    localparam int unsigned UART_CLKS_PER_BIT = 10416;
    localparam int unsigned UART_BW           = 8;

    function automatic logic even_parity(input logic [UART_BW-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; writes while full and reads while
// empty are dropped so the stored contents are never corrupted.
module uart_sync_fifo #(
    parameter int unsigned BW    = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_i,
    input  logic [BW-1:0]          wr_data_i,
    input  logic                   rd_i,
    output logic [BW-1:0]          rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [BW-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            wr_en, rd_en;

    assign full_o    = (count_q == CntW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign wr_en = wr_i && !full_o;
    assign rd_en = rd_i && !empty_o;

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serializer producing start/data/stop frames.
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BW           = UART_BW,
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic [BW-1:0]          i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = (BW > 1) ? $clog2(BW) : 1;

    tx_state_t       state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [BW-1:0]   shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            load;
    logic            baud_last;
    logic            fifo_full, fifo_empty;
    logic [BW-1:0]   fifo_rdata;

    uart_sync_fifo #(
        .BW    (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (i_reset),
        .wr_i      (i_valid),
        .wr_data_i (i_data),
        .rd_i      (load),
        .rd_data_o (fifo_rdata),
        .count_o   (o_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign o_ready   = !fifo_full;
    assign o_tx      = tx_q;
    assign o_busy    = busy_q;
    assign baud_last = (baud_q == CntW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                load = !fifo_empty;
            end
            StStart: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q == IdxW'(BW - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
`endif
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    // A queued word chains straight into the next start bit.
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
            end
        endcase

        if (load) begin
            state_d = StStart;
            baud_d  = '0;
            idx_d   = '0;
            shift_d = fifo_rdata;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = load ? even_parity(fifo_rdata) : parity_q;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // Line level is computed from the next state so o_tx is a clean flop output.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: per-cycle line model plus literal frame checks.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int BW    = 8;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = BW + 3;
`else
    localparam int NBITS = BW + 2;
`endif
    localparam int FRAME = NBITS * C;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [BW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready, o_tx, o_busy;
    logic [4:0]    o_count;

    uart_tx_fifo #(
        .BW           (BW),
        .CLKS_PER_BIT (C),
        .DEPTH        (DEPTH)
    ) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Model: queued words plus the remaining per-cycle line levels of the current frame.
    logic [BW-1:0] mq[$];
    bit            line[$];
    bit            exp_tx = 1'b1;
    bit            exp_busy = 1'b0;
    int            exp_count = 0;
    bit            m_pop, m_acc;

    function automatic void push_frame(input logic [BW-1:0] w);
        for (int k = 0; k < C; k++) line.push_back(1'b0);
        for (int b = 0; b < BW; b++)
            for (int k = 0; k < C; k++) line.push_back(w[b]);
`ifdef UART_TX_PARITY_EN
        for (int k = 0; k < C; k++) line.push_back(^w);
`endif
        for (int k = 0; k < C; k++) line.push_back(1'b1);
    endfunction

    always @(posedge clk) begin
        if (i_reset) begin
            mq.delete();
            line.delete();
        end else begin
            m_pop = (mq.size() > 0) && (line.size() <= 1);
            m_acc = i_valid && (mq.size() != DEPTH);
            if (line.size() > 0) void'(line.pop_front());
            if (m_pop) push_frame(mq.pop_front());
            if (m_acc) mq.push_back(i_data);
        end
        exp_tx    = (line.size() > 0) ? line[0] : 1'b1;
        exp_busy  = (line.size() > 0);
        exp_count = mq.size();
    end

    always @(negedge clk) begin
        if (chk_en && !i_reset) begin
            chk("tx", int'(o_tx), int'(exp_tx));
            chk("busy", int'(o_busy), int'(exp_busy));
            chk("count", int'(o_count), exp_count);
            chk("ready", int'(o_ready), int'(exp_count != DEPTH));
        end
    end

    int s[FRAME];

    task automatic write_word(input logic [BW-1:0] w);
        i_valid = 1'b1;
        i_data  = w;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            s[i] = int'(o_tx);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((o_busy || o_count != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", int'(n < budget), 1);
    endtask

    int pat[11];
    int acc;
    int e;
    int busy_cyc;

    initial begin
        // Reset held for three edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", int'(o_tx), 1);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_count", int'(o_count), 0);
        i_reset = 1'b0;
        chk_en  = 1'b1;

        // 0xA5 frame, literal bit pattern.
`ifdef UART_TX_PARITY_EN
        pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
        write_word(8'hA5);
        capture_frame();
        for (int b = 0; b < NBITS; b++) begin
            chk($sformatf("a5_bit%0d_first", b), s[b*C], pat[b]);
            chk($sformatf("a5_bit%0d_last", b), s[b*C+C-1], pat[b]);
        end
        @(negedge clk);
        chk("a5_idle_busy", int'(o_busy), 0);
        chk("a5_idle_tx", int'(o_tx), 1);

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x07 -> 1, 0x03 -> 0, each 44 cycles busy.
        write_word(8'h07);
        capture_frame();
        chk("p07_parity", s[(BW+1)*C], 1);
        busy_cyc = 0;
        while (o_busy && busy_cyc < 100) begin
            @(negedge clk);
            busy_cyc++;
        end
        chk("p07_frame_len", busy_cyc + FRAME - 1, 44);
        write_word(8'h03);
        capture_frame();
        chk("p03_parity", s[(BW+1)*C+C-1], 0);
        wait_idle(100);
`endif

        // Hold i_valid for 20 cycles from idle.
        acc = 0;
        for (int k = 1; k <= 20; k++) begin
            i_valid = 1'b1;
            i_data  = BW'($urandom);
            if (o_ready) acc++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        chk("burst_accepted", acc, 17);
        chk("burst_full_count", int'(o_count), 16);
        chk("burst_full_ready", int'(o_ready), 0);
        e = 20;
        while (!o_ready && e < 400) begin
            @(negedge clk);
            e++;
        end
        chk("ready_rise_edge", e, 2 + FRAME);
        // Write during the final stop cycle of frame 2 with 15 queued.
        while (e < 1 + 2 * FRAME) begin
            @(negedge clk);
            e++;
        end
        chk("stop_last_count", int'(o_count), 15);
        write_word(BW'($urandom));
        chk("simul_count", int'(o_count), 15);
        chk("simul_start_tx", int'(o_tx), 0);
        chk("simul_busy", int'(o_busy), 1);
        wait_idle(17 * FRAME + 100);

        // Reset during data bit 3 with five words queued.
        write_word(8'hF0);
        for (int k = 0; k < 5; k++) write_word(BW'($urandom));
        repeat (13) @(negedge clk);
        chk("pre_reset_tx", int'(o_tx), 0);
        #2 i_reset = 1'b1;
        #1;
        chk("async_rst_tx", int'(o_tx), 1);
        chk("async_rst_count", int'(o_count), 0);
        chk("async_rst_busy", int'(o_busy), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        write_word(8'h3C);
        busy_cyc = 0;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(negedge clk);
            if (o_busy) busy_cyc++;
        end
        chk("post_rst_frame_len", busy_cyc, FRAME);

        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            i_valid = ($urandom_range(0, 3) == 0);
            i_data  = BW'($urandom);
            @(negedge clk);
        end
        i_valid = 1'b0;
        wait_idle((DEPTH + 2) * FRAME + 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
